// File: rtl/xor_pkg.sv
// Shared types and helpers for the XOR frame accumulator.
// State encoding plus a parity helper usable by block and checker.
package xor_pkg;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    localparam int XOR_MAX_W = 256;

    function automatic logic xor_reduce(input logic [XOR_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/xor_reduce_w.sv
// Parametrised WIDTH-bit XOR reduction, purely combinational.
// Shared by the accumulator and the integrity checker.
module xor_reduce_w #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    always_comb begin
        parity = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            parity = parity ^ data[i];
        end
    end

endmodule

// File: rtl/xor_frame_accum.sv
// Frame-wise XOR accumulator with valid/ready on both sides.
// Emits signature, parity, word count and overrun per frame.
module xor_frame_accum
    import xor_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MAX_LEN    = 16,
    parameter int ODD_PARITY = 0,
    parameter int CNT_W      = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overrun,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             close;
    logic             accept;
    logic             parity_raw;

    assign acc_next = acc ^ in_data;
    assign cnt_next = cnt + CNT_W'(1);
    assign close    = in_last || (cnt_next == CNT_W'(MAX_LEN));
    assign accept   = in_valid && (state == ACC);

    // Both handshake outputs decode straight from the state flop.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == OUT);

    xor_reduce_w #(
        .WIDTH (WIDTH)
    ) u_par (
        .data   (acc_next),
        .parity (parity_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ACC;
            acc         <= '0;
            cnt         <= '0;
            out_data    <= '0;
            out_count   <= '0;
            out_parity  <= 1'b0;
            out_overrun <= 1'b0;
        end else begin
            unique case (state)
                ACC: begin
                    if (accept) begin
                        if (close) begin
                            out_data    <= acc_next;
                            out_count   <= cnt_next;
                            out_overrun <= ~in_last;
                            out_parity  <= parity_raw ^ 1'(ODD_PARITY);
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= OUT;
                        end else begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
